// File: rtl/me_sad_engine.sv
`default_nettype none
// ============================================================================
// Module      : me_sad_engine
// Description : Full-search block-matching motion estimator. A 16x16
//               reference block is matched against all 16x16 candidate
//               offsets of a 32-column search area by sum of absolute
//               differences (SAD). Two horizontally adjacent candidates
//               (mx even on S1, mx+1 on S2) are evaluated per pass.
// Ports       : clk        - clock, all state on the rising edge
//               reset      - asynchronous active-high reset
//               start      - single-cycle request, honoured in IDLE/DONE only
//               AddressR   - reference memory address (r*16 + c)
//               AddressS1  - search address for the even candidate
//               AddressS2  - search address for the odd candidate
//               R/S1/S2    - memory read data, one cycle after the address
//               motionX/Y  - best candidate offset
//               BestDist   - best SAD, saturated to BEST_W bits
//               completed  - high from end of search until next start
// Revision    : 1.0 - initial release
// ============================================================================
module me_sad_engine #(
    parameter int DATA_W = 8,
    parameter int SAD_W  = 16,
    parameter int BEST_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [7:0]        AddressR,
    output logic [9:0]        AddressS1,
    output logic [9:0]        AddressS2,
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] S1,
    input  logic [DATA_W-1:0] S2,
    output logic [3:0]        motionX,
    output logic [3:0]        motionY,
    output logic [BEST_W-1:0] BestDist,
    output logic              completed
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_start_acc;

    logic [7:0]        r_p;
    logic [3:0]        r_mx;
    logic [3:0]        r_my;
    logic [7:0]        r_addr_r;
    logic [9:0]        r_addr_s1;
    logic [9:0]        r_addr_s2;
    logic              r_acc_en;
    logic [SAD_W-1:0]  r_acc_a;
    logic [SAD_W-1:0]  r_acc_b;
    logic [SAD_W-1:0]  r_best;
    logic [3:0]        r_best_x;
    logic [3:0]        r_best_y;
    logic [3:0]        r_motion_x;
    logic [3:0]        r_motion_y;
    logic [BEST_W-1:0] r_best_dist;
    logic              r_completed;

    // Search address: row (my+r) times 32 plus column (mx+c). The column
    // sum never exceeds 29, so the multiply-add reduces to concatenation.
    function automatic logic [9:0] f_s_addr(input logic [3:0] my,
                                            input logic [3:0] mx,
                                            input logic [7:0] p);
        logic [4:0] row;
        logic [4:0] col;
        row = {1'b0, my} + {1'b0, p[7:4]};
        col = {1'b0, mx} + {1'b0, p[3:0]};
        return {row, col};
    endfunction

    // ------------------------------------------------------------------
    // Absolute differences for the two candidates
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_diff_a;
    logic [DATA_W-1:0] w_diff_b;

    assign w_diff_a = (R > S1) ? (R - S1) : (S1 - R);
    assign w_diff_b = (R > S2) ? (R - S2) : (S2 - R);

    // ------------------------------------------------------------------
    // Candidate comparison: even candidate first, then odd against the
    // possibly updated best, so ties keep the earlier candidate.
    // ------------------------------------------------------------------
    logic              w_a_win;
    logic              w_b_win;
    logic [SAD_W-1:0]  w_best_1;
    logic [3:0]        w_bx_1;
    logic [3:0]        w_by_1;
    logic [SAD_W-1:0]  w_best_2;
    logic [3:0]        w_bx_2;
    logic [3:0]        w_by_2;
    logic [BEST_W-1:0] w_sat_dist;
    logic              w_last;
    logic [3:0]        w_next_mx;
    logic [3:0]        w_next_my;
    logic [7:0]        w_p_inc;

    assign w_a_win  = (r_acc_a < r_best);
    assign w_best_1 = w_a_win ? r_acc_a : r_best;
    assign w_bx_1   = w_a_win ? r_mx : r_best_x;
    assign w_by_1   = w_a_win ? r_my : r_best_y;

    assign w_b_win  = (r_acc_b < w_best_1);
    assign w_best_2 = w_b_win ? r_acc_b : w_best_1;
    assign w_bx_2   = w_b_win ? (r_mx | 4'd1) : w_bx_1;
    assign w_by_2   = w_b_win ? r_my : w_by_1;

    assign w_sat_dist = (|w_best_2[SAD_W-1:BEST_W]) ? {BEST_W{1'b1}}
                                                     : w_best_2[BEST_W-1:0];

    assign w_last    = (r_mx == 4'd14) && (r_my == 4'd15);
    // mx steps by two and wraps 14 -> 0 naturally in four bits
    assign w_next_mx = r_mx + 4'd2;
    assign w_next_my = (r_mx == 4'd14) ? (r_my + 4'd1) : r_my;
    assign w_p_inc   = r_p + 8'd1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_acc  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start_acc  = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_p == 8'hFF) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_next_state = ST_CMP;
            end
            ST_CMP: begin
                w_next_state = w_last ? ST_DONE : ST_RUN;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. The address registers always hold the address for the
    // current pixel index, so read data lines up one cycle later; r_acc_en
    // marks those data cycles (RUN cycles 1..255 plus DRAIN).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p         <= '0;
            r_mx        <= '0;
            r_my        <= '0;
            r_addr_r    <= '0;
            r_addr_s1   <= '0;
            r_addr_s2   <= '0;
            r_acc_en    <= 1'b0;
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_best      <= '0;
            r_best_x    <= '0;
            r_best_y    <= '0;
            r_motion_x  <= '0;
            r_motion_y  <= '0;
            r_best_dist <= '0;
            r_completed <= 1'b0;
        end else begin
            r_acc_en <= (r_state == ST_RUN);

            if (w_start_acc) begin
                r_p         <= '0;
                r_mx        <= '0;
                r_my        <= '0;
                r_addr_r    <= '0;
                r_addr_s1   <= 10'd0;
                r_addr_s2   <= 10'd1;
                r_acc_a     <= '0;
                r_acc_b     <= '0;
                r_best      <= '1;
                r_best_x    <= '0;
                r_best_y    <= '0;
                r_completed <= 1'b0;
            end else if (r_state == ST_CMP) begin
                r_best    <= w_best_2;
                r_best_x  <= w_bx_2;
                r_best_y  <= w_by_2;
                r_acc_a   <= '0;
                r_acc_b   <= '0;
                r_p       <= '0;
                r_mx      <= w_next_mx;
                r_my      <= w_next_my;
                r_addr_r  <= '0;
                r_addr_s1 <= f_s_addr(w_next_my, w_next_mx, 8'd0);
                r_addr_s2 <= f_s_addr(w_next_my, w_next_mx, 8'd0) + 10'd1;
                if (w_last) begin
                    r_motion_x  <= w_bx_2;
                    r_motion_y  <= w_by_2;
                    r_best_dist <= w_sat_dist;
                    r_completed <= 1'b1;
                end
            end else begin
                if ((r_state == ST_RUN) && (r_p != 8'hFF)) begin
                    r_p       <= w_p_inc;
                    r_addr_r  <= w_p_inc;
                    r_addr_s1 <= f_s_addr(r_my, r_mx, w_p_inc);
                    r_addr_s2 <= f_s_addr(r_my, r_mx, w_p_inc) + 10'd1;
                end
                if (r_acc_en) begin
                    r_acc_a <= r_acc_a + {{(SAD_W-DATA_W){1'b0}}, w_diff_a};
                    r_acc_b <= r_acc_b + {{(SAD_W-DATA_W){1'b0}}, w_diff_b};
                end
            end
        end
    end

    assign AddressR  = r_addr_r;
    assign AddressS1 = r_addr_s1;
    assign AddressS2 = r_addr_s2;
    assign motionX   = r_motion_x;
    assign motionY   = r_motion_y;
    assign BestDist  = r_best_dist;
    assign completed = r_completed;

endmodule
`default_nettype wire

// File: tb/tb_me_sad_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_me_sad_engine
// Description : Self-checking bench for me_sad_engine with behavioural
//               reference/search memories and an exhaustive SAD model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_me_sad_engine;

    localparam int C_LATENCY = 33024;
    localparam int C_TIMEOUT = 34000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] AddressR;
    logic [9:0] AddressS1;
    logic [9:0] AddressS2;
    logic [7:0] R;
    logic [7:0] S1;
    logic [7:0] S2;
    logic [3:0] motionX;
    logic [3:0] motionY;
    logic [7:0] BestDist;
    logic       completed;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [0:255];
    logic [7:0] srch    [0:1023];

    logic searching = 1'b0;
    logic clr_max   = 1'b0;
    int   max_s2    = 0;
    int   pair_err  = 0;

    me_sad_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .R         (R),
        .S1        (S1),
        .S2        (S2),
        .motionX   (motionX),
        .motionY   (motionY),
        .BestDist  (BestDist),
        .completed (completed)
    );

    always #5 clk = ~clk;

    // Synchronous memories with one cycle of read latency
    always @(posedge clk) begin
        R  <= ref_mem[AddressR];
        S1 <= srch[AddressS1];
        S2 <= srch[AddressS2];
    end

    always @(posedge clk) begin
        if (clr_max) max_s2 <= 0;
        else if (int'(AddressS2) > max_s2) max_s2 <= int'(AddressS2);
        if (searching && (AddressS2 !== AddressS1 + 10'd1)) pair_err <= pair_err + 1;
    end

    // Exhaustive reference: every candidate in scan order, strict less-than
    task automatic model(output int ex_x, output int ex_y, output int ex_d);
        int best;
        best = 32'h7FFF_FFFF;
        ex_x = 0;
        ex_y = 0;
        for (int my = 0; my < 16; my++) begin
            for (int mx = 0; mx < 16; mx++) begin
                int sad;
                sad = 0;
                for (int r = 0; r < 16; r++) begin
                    for (int c = 0; c < 16; c++) begin
                        int a;
                        int b;
                        a = int'(ref_mem[r*16 + c]);
                        b = int'(srch[(my + r)*32 + mx + c]);
                        sad += (a > b) ? (a - b) : (b - a);
                    end
                end
                if (sad < best) begin
                    best = sad;
                    ex_x = mx;
                    ex_y = my;
                end
            end
        end
        ex_d = (best > 255) ? 255 : best;
    endtask

    // Accept a start, then count cycles until completed (bounded)
    task automatic run_search(input bit pulses, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        searching = 1'b1;
        cycles    = 0;
        n_cmp++;
        if (completed !== 1'b0) begin
            n_bad++;
            $display("FAIL completed_cleared_on_start: got %0b want 0", completed);
        end
        while (completed !== 1'b1 && cycles < C_TIMEOUT) begin
            if (pulses) start = (cycles == 10) || (cycles == 20000);
            @(posedge clk);
            #1;
            cycles++;
        end
        start     = 1'b0;
        searching = 1'b0;
    endtask

    task automatic check_result(input string tag, input int cycles,
                                input int ex_x, input int ex_y, input int ex_d);
        n_cmp++;
        if (cycles != C_LATENCY) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d cycles want %0d", tag, cycles, C_LATENCY);
        end
        n_cmp++;
        if (motionX !== 4'(ex_x)) begin
            n_bad++;
            $display("FAIL %s_motionX: got %0d want %0d", tag, motionX, ex_x);
        end
        n_cmp++;
        if (motionY !== 4'(ex_y)) begin
            n_bad++;
            $display("FAIL %s_motionY: got %0d want %0d", tag, motionY, ex_y);
        end
        n_cmp++;
        if (BestDist !== 8'(ex_d)) begin
            n_bad++;
            $display("FAIL %s_BestDist: got %0d want %0d", tag, BestDist, ex_d);
        end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (completed !== 1'b1 || motionX !== 4'(ex_x) || motionY !== 4'(ex_y)) begin
            n_bad++;
            $display("FAIL %s_done_hold: completed=%0b mx=%0d my=%0d want 1,%0d,%0d",
                     tag, completed, motionX, motionY, ex_x, ex_y);
        end
        n_cmp++;
        if (pair_err != 0) begin
            n_bad++;
            $display("FAIL %s_s2_is_s1_plus1: got %0d violations want 0", tag, pair_err);
        end
    endtask

    task automatic test_reset();
        logic [44:0] obs;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {AddressR, AddressS1, AddressS2, motionX, motionY, BestDist, completed};
        n_cmp++;
        if (obs !== 45'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (completed !== 1'b0 || AddressS1 !== 10'd0) begin
            n_bad++;
            $display("FAIL idle_quiet: completed=%0b s1=%0d want 0,0", completed, AddressS1);
        end
    endtask

    // Random reference copied into a random background, with ignored starts
    task automatic test_planted_with_pulses();
        int ex_x, ex_y, ex_d, cyc;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) srch[i] = 8'($urandom);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                srch[(5 + r)*32 + 8 + c] = ref_mem[r*16 + c];
        model(ex_x, ex_y, ex_d);
        run_search(1'b1, cyc);
        check_result("planted", cyc, ex_x, ex_y, ex_d);
    endtask

    // Restart from DONE, check results hold, then reset mid-search
    task automatic test_reset_mid(input int pv_x, input int pv_y, input int pv_d);
        logic [44:0] obs;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if (completed !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_clears_completed: got %0b want 0", completed);
        end
        repeat (998) @(posedge clk);
        #1;
        n_cmp++;
        if (motionX !== 4'(pv_x) || motionY !== 4'(pv_y) || BestDist !== 8'(pv_d)) begin
            n_bad++;
            $display("FAIL hold_while_running: got %0d,%0d,%0d want %0d,%0d,%0d",
                     motionX, motionY, BestDist, pv_x, pv_y, pv_d);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        obs = {AddressR, AddressS1, AddressS2, motionX, motionY, BestDist, completed};
        n_cmp++;
        if (obs !== 45'd0) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: got %h want 0", obs);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Ties and saturation: R all 0, S all 2 with one zero pixel. Every
    // candidate covering the zero pixel shares the minimum SAD of 510.
    task automatic test_tie_saturate();
        int ex_x, ex_y, ex_d, cyc, ex_max;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        for (int i = 0; i < 1024; i++) srch[i] = 8'd2;
        srch[20*32 + 22] = 8'd0;
        model(ex_x, ex_y, ex_d);
        ex_max = (15 + 15)*32 + 14 + 15 + 1;
        @(negedge clk);
        clr_max = 1'b1;
        @(negedge clk);
        clr_max = 1'b0;
        run_search(1'b0, cyc);
        check_result("tie_sat", cyc, ex_x, ex_y, ex_d);
        n_cmp++;
        if (max_s2 != ex_max) begin
            n_bad++;
            $display("FAIL max_AddressS2: got %0d want %0d", max_s2, ex_max);
        end
    endtask

    initial begin
        int pv_x, pv_y, pv_d;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        for (int i = 0; i < 1024; i++) srch[i] = 8'd0;
        test_reset();
        test_planted_with_pulses();
        model(pv_x, pv_y, pv_d);
        test_reset_mid(pv_x, pv_y, pv_d);
        test_tie_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
